// File: rtl/seg_scan_pkg.sv
// Shared constants, state type and helper for the segment-scan readback decoder.
package seg_scan_pkg;

  // Active-low segment patterns, bit 6 = g ... bit 0 = a.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {IDLE, SETTLING, CAPTURED} scan_state_t;

  // True when exactly one anode line is driven low.
  function automatic logic is_one_cold(input logic [7:0] v);
    return ($countones(~v) == 1);
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational 7-segment pattern to BCD decoder.
// Build option: SEG_SCAN_BLANK_EN makes the all-dark pattern a legal blank digit.
module seg_pattern_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_value,
  output logic       o_legal
);

  // Map each recognised pattern to its value; anything else is flagged illegal.
  always_comb begin
    o_value = BLANK_CODE;
    o_legal = 1'b1;
    case (i_seg)
      SEG_0: o_value = 4'd0;
      SEG_1: o_value = 4'd1;
      SEG_2: o_value = 4'd2;
      SEG_3: o_value = 4'd3;
      SEG_4: o_value = 4'd4;
      SEG_5: o_value = 4'd5;
      SEG_6: o_value = 4'd6;
      SEG_7: o_value = 4'd7;
      SEG_8: o_value = 4'd8;
      SEG_9: o_value = 4'd9;
`ifdef SEG_SCAN_BLANK_EN
      SEG_BLANK: o_value = BLANK_CODE;
`else
      SEG_BLANK: o_legal = 1'b0;
`endif
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Readback decoder for the multiplexed 7-segment display bus.
// Synchronizes seg/anode, waits SETTLE_CYCLES stable cycles per dwell,
// decodes the pattern and tracks frame completion over all eight digits.
// Build option: SEG_SCAN_BLANK_EN (handled in seg_pattern_decode).
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [7:0]  a,
  output logic [31:0] digits,
  output logic [7:0]  digit_valid,
  output logic        frame_done,
  output logic        err_pattern,
  output logic        err_anode
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [6:0]       r_seg_m, r_seg_s;
  logic [7:0]       r_a_m, r_a_s;
  scan_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_change, w_capture, w_enter_idle;
  logic [2:0]       w_idx;
  logic [3:0]       w_dec_value;
  logic             w_dec_legal;
  logic [7:0]       r_mask, w_mask_set;
  logic [31:0]      r_digits;
  logic [7:0]       r_valid;
  logic             r_frame_done, r_err_pattern, r_err_anode;

  // Two-flop synchronizers; idle bus level (all ones) out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_m <= '1;
      r_seg_s <= '1;
      r_a_m   <= '1;
      r_a_s   <= '1;
    end else begin
      r_seg_m <= seg;
      r_seg_s <= r_seg_m;
      r_a_m   <= a;
      r_a_s   <= r_a_m;
    end
  end

  // The synchronized bus changes on the coming edge; the count restarts so
  // that cnt==0 marks the first cycle the new value is visible in seg_s/a_s.
  assign w_change = ({r_a_m, r_seg_m} != {r_a_s, r_seg_s});

  // Next-state and settle counter; capture fires once per settled dwell.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    if (w_change) begin
      w_cnt_nxt   = '0;
      w_state_nxt = is_one_cold(r_a_m) ? SETTLING : IDLE;
    end else begin
      case (r_state)
        SETTLING: begin
          if (r_cnt == CNT_LAST) begin
            w_capture   = 1'b1;
            w_state_nxt = CAPTURED;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_enter_idle = w_change && (w_state_nxt == IDLE) && (r_state != IDLE);

  // State register and settle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Position of the single low anode bit (only meaningful while settling).
  always_comb begin
    w_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!r_a_s[i]) w_idx = i[2:0];
    end
  end

  seg_pattern_decode u_decode (
    .i_seg   (r_seg_s),
    .o_value (w_dec_value),
    .o_legal (w_dec_legal)
  );

  assign w_mask_set = r_mask | (8'd1 << w_idx);

  // Digit store, frame mask and one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits      <= '1;
      r_valid       <= '0;
      r_mask        <= '0;
      r_frame_done  <= 1'b0;
      r_err_pattern <= 1'b0;
      r_err_anode   <= 1'b0;
    end else begin
      r_frame_done  <= 1'b0;
      r_err_pattern <= w_capture && !w_dec_legal;
      r_err_anode   <= w_enter_idle;
      if (w_capture) begin
        if (w_dec_legal) begin
          r_digits[{w_idx, 2'b00} +: 4] <= w_dec_value;
          r_valid[w_idx]                <= 1'b1;
        end else begin
          r_valid[w_idx] <= 1'b0;
        end
        if (w_mask_set == 8'hFF) begin
          r_mask       <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_mask <= w_mask_set;
        end
      end
    end
  end

  assign digits      = r_digits;
  assign digit_valid = r_valid;
  assign frame_done  = r_frame_done;
  assign err_pattern = r_err_pattern;
  assign err_anode   = r_err_anode;

endmodule
